// File: rtl/mem_port_arbiter.sv
// Shared APB data-memory port arbiter for two requesters (processor lw/sw path
// and a loader/DMA engine). Latches the winning request, runs the APB
// SETUP/ACCESS phases and returns data plus a completion/timeout strobe.
module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int WAIT_MAX   = 15,
   parameter int PRIO_FIXED = 0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_req_valid,
   input  logic [1:0]        i_req_write,
   input  logic [1:0]        i_req_sel,
   input  logic [ADDR_W-1:0] i_req0_addr,
   input  logic [ADDR_W-1:0] i_req1_addr,
   input  logic [DATA_W-1:0] i_req0_wdata,
   input  logic [DATA_W-1:0] i_req1_wdata,
   output logic [1:0]        o_req_ready,
   output logic [1:0]        o_req_err,
   output logic [DATA_W-1:0] o_rdata,
   output logic [1:0]        o_grant,
   output logic [1:0]        o_psel,
   output logic              o_penable,
   output logic              o_pwrite,
   output logic [ADDR_W-1:0] o_paddr,
   output logic [DATA_W-1:0] o_pwdata,
   input  logic [DATA_W-1:0] i_prdata,
   input  logic              i_pready
);

   // wait counter only has to reach WAIT_MAX-1, so it can never wrap
   localparam int              CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   typedef struct packed {
      logic              write;
      logic              sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t            r_state;
   logic [1:0]        r_grant;
   logic [1:0]        r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_last;      // index of the last requester served
   logic [CNT_W-1:0]  r_wait_cnt;

   logic              w_win;
   req_t              w_req;
   logic              w_done;

   // pick the winner among valid requesters and mux its fields
   always_comb begin
      w_win = 1'b0;
      w_req = '0;
      case (i_req_valid)
         2'b10:   w_win = 1'b1;
         2'b11:   w_win = (PRIO_FIXED != 0) ? 1'b0 : ~r_last;
         default: w_win = 1'b0;
      endcase
      if (w_win) begin
         w_req.write = i_req_write[1];
         w_req.sel   = i_req_sel[1];
         w_req.addr  = i_req1_addr;
         w_req.wdata = i_req1_wdata;
      end else begin
         w_req.write = i_req_write[0];
         w_req.sel   = i_req_sel[0];
         w_req.addr  = i_req0_addr;
         w_req.wdata = i_req0_wdata;
      end
   end

   // a transfer ends on slave ready or when the wait budget runs out
   assign w_done = (r_state == S_ACCESS) && (i_pready || (r_wait_cnt == CNT_LAST));

   // completion strobes are combinational so the requester sees them in ACCESS
   always_comb begin
      o_req_ready = w_done ? r_grant : 2'b00;
      o_req_err   = (w_done && !i_pready) ? r_grant : 2'b00;
      o_rdata     = (w_done && i_pready && !r_pwrite) ? i_prdata : '0;
   end

   // APB sequencing FSM with registered bus outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_grant    <= 2'b00;
         r_psel     <= 2'b00;
         r_penable  <= 1'b0;
         r_pwrite   <= 1'b0;
         r_paddr    <= '0;
         r_pwdata   <= '0;
         r_last     <= 1'b1;     // requester 0 wins the first tie
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|i_req_valid) begin
                  r_grant  <= w_win ? 2'b10 : 2'b01;
                  r_psel   <= w_req.sel ? 2'b10 : 2'b01;
                  r_pwrite <= w_req.write;
                  r_paddr  <= w_req.addr;
                  r_pwdata <= w_req.wdata;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_penable  <= 1'b1;
               r_wait_cnt <= '0;
               r_state    <= S_ACCESS;
            end
            S_ACCESS: begin
               if (w_done) begin
                  r_last    <= r_grant[1];
                  r_grant   <= 2'b00;
                  r_psel    <= 2'b00;
                  r_penable <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            default: begin
               r_grant   <= 2'b00;
               r_psel    <= 2'b00;
               r_penable <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign o_grant   = r_grant;
   assign o_psel    = r_psel;
   assign o_penable = r_penable;
   assign o_pwrite  = r_pwrite;
   assign o_paddr   = r_paddr;
   assign o_pwdata  = r_pwdata;

endmodule
